multicycle_controller: RTL and testbench

- Multi-cycle sequencing FSM for the RV32I datapath: drives the existing control set (RegWrite, MemtoReg, ALUSrc, MemWrite, MemRead, ALUOp) plus PC/IR enables over several cycles per instruction.
- Replaces the single-cycle combinational Controller when instruction and data memory have variable latency.
- The ALUOp output feeds the existing ALU controller unchanged.
- Also provides a memory-wait watchdog, an illegal-opcode trap, and a retired-instruction counter.

---
 rtl/multicycle_controller_if.sv | 19 +
 rtl/multicycle_controller.sv | 111 +++++++++++
 tb/tb_multicycle_controller.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: control/handshake bundle between the sequencer and the RV32I datapath.
interface multicycle_controller_if #(parameter int CNT_W = 32);
  logic [6:0] Opcode;
  logic instr_ready, data_ready, zero;
  logic instr_req, IRWrite, PCWrite, PCBranch, RegWrite, MemtoReg, ALUSrc, MemRead, MemWrite;
  logic [1:0] ALUOp, trap_cause;
  logic trap;
  logic [CNT_W-1:0] retired;
  modport master (
    input Opcode, instr_ready, data_ready, zero,
    output instr_req, IRWrite, PCWrite, PCBranch, RegWrite, MemtoReg, ALUSrc, MemRead, MemWrite,
    output ALUOp, trap, trap_cause, retired
  );
  modport slave (
    output Opcode, instr_ready, data_ready, zero,
    input instr_req, IRWrite, PCWrite, PCBranch, RegWrite, MemtoReg, ALUSrc, MemRead, MemWrite,
    input ALUOp, trap, trap_cause, retired
  );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: multi-cycle RV32I sequencer with memory-wait watchdog, illegal-opcode trap and retire counter.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic reset,
  multicycle_controller_if.master bus
);
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011;
  localparam logic [7:0] LAST = 8'(MEM_TIMEOUT - 1);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
  state_t state, nxt;
  logic [7:0] wcnt;
  logic [6:0] op;
  logic [1:0] cause, nxt_cause, aop, exec_aop;
  logic [CNT_W-1:0] retired;
  logic inc, tmo, legal, is_r, is_i, is_ld, is_st, is_br, exec_src;
  logic ireq, irw, pcw, pcb, rw, m2r, als, mr, mw;
  assign is_r = op == OP_R;
  assign is_i = op == OP_I;
  assign is_ld = op == OP_LD;
  assign is_st = op == OP_ST;
  assign is_br = op == OP_BR;
  assign exec_src = is_i | is_ld | is_st;
  assign exec_aop = (is_r | is_i) ? 2'b10 : is_br ? 2'b01 : 2'b00;
  assign tmo = wcnt == LAST;
  assign legal = bus.Opcode inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR};
  always_comb begin
    nxt = state;
    nxt_cause = cause;
    inc = 1'b0;
    ireq = 1'b0;
    irw = 1'b0;
    pcw = 1'b0;
    pcb = 1'b0;
    rw = 1'b0;
    m2r = 1'b0;
    als = 1'b0;
    mr = 1'b0;
    mw = 1'b0;
    aop = 2'b00;
    case (state)
      FETCH: begin
        ireq = 1'b1;
        irw = bus.instr_ready;
        pcw = bus.instr_ready;
        nxt = bus.instr_ready ? DECODE : tmo ? TRAP : FETCH;
        nxt_cause = (!bus.instr_ready && tmo) ? 2'b10 : cause;
      end
      DECODE: begin
        nxt = legal ? EXEC : TRAP;
        nxt_cause = legal ? cause : 2'b01;
      end
      EXEC: begin
        als = exec_src;
        aop = exec_aop;
        pcb = is_br & bus.zero;
        inc = is_br;
        nxt = is_br ? FETCH : (is_ld | is_st) ? MEM : WB;
      end
      MEM: begin
        als = 1'b1;
        mr = is_ld;
        mw = is_st;
        inc = bus.data_ready & is_st;
        nxt = bus.data_ready ? (is_st ? FETCH : WB) : tmo ? TRAP : MEM;
        nxt_cause = (!bus.data_ready && tmo) ? 2'b11 : cause;
      end
      WB: begin
        rw = 1'b1;
        m2r = is_ld;
        als = exec_src;
        aop = exec_aop;
        inc = 1'b1;
        nxt = FETCH;
      end
      default: nxt = TRAP;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
      wcnt <= 8'd0;
      op <= 7'd0;
      cause <= 2'b00;
      retired <= '0;
    end else begin
      state <= nxt;
      wcnt <= (nxt != state || state == TRAP) ? 8'd0 : wcnt + 8'd1;
      if (state == DECODE) op <= bus.Opcode;
      cause <= nxt_cause;
      if (inc) retired <= retired + CNT_W'(1);
    end
  end
  // Strobes are gated by reset so nothing leaks while it is held low.
  assign bus.instr_req = reset & ireq;
  assign bus.IRWrite = reset & irw;
  assign bus.PCWrite = reset & pcw;
  assign bus.PCBranch = reset & pcb;
  assign bus.RegWrite = reset & rw;
  assign bus.MemtoReg = reset & m2r;
  assign bus.ALUSrc = reset & als;
  assign bus.MemRead = reset & mr;
  assign bus.MemWrite = reset & mw;
  assign bus.ALUOp = reset ? aop : 2'b00;
  assign bus.trap = state == TRAP;
  assign bus.trap_cause = cause;
  assign bus.retired = retired;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: randomized instruction streams checked against a per-instruction cycle-by-cycle reference.
module tb_multicycle_controller;
  localparam int TMO = 16;
  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011,
                         ST = 7'b0100011, BR = 7'b1100011, BAD = 7'b1111111;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int errs = 0, checks = 0, ncyc = 0;
  logic [31:0] mret = 32'd0;
  always #5 clk = ~clk;
  multicycle_controller_if #(.CNT_W(32)) bus();
  multicycle_controller #(.MEM_TIMEOUT(TMO), .CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(bus.master));
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [13:0] obs();
    return {bus.instr_req, bus.IRWrite, bus.PCWrite, bus.PCBranch, bus.RegWrite, bus.MemtoReg,
            bus.ALUSrc, bus.MemRead, bus.MemWrite, bus.ALUOp, bus.trap, bus.trap_cause};
  endfunction
  function automatic logic [13:0] ex(logic ir, logic irw, logic pcw, logic pcb, logic rw, logic m2r,
                                     logic als, logic mr, logic mw, logic [1:0] aop, logic t, logic [1:0] c);
    return {ir, irw, pcw, pcb, rw, m2r, als, mr, mw, aop, t, c};
  endfunction
  function automatic logic legal(logic [6:0] op);
    return op == R || op == I || op == LD || op == ST || op == BR;
  endfunction
  function automatic logic src(logic [6:0] op);
    return op == I || op == LD || op == ST;
  endfunction
  function automatic logic [1:0] aop(logic [6:0] op);
    return (op == R || op == I) ? 2'b10 : (op == BR) ? 2'b01 : 2'b00;
  endfunction
  task automatic step(string tag, logic [13:0] e);
    @(negedge clk);
    chk(tag, 32'(obs()), 32'(e));
    chk({tag, "_retired"}, bus.retired, mret);
    @(posedge clk);
    #1;
    ncyc++;
    bus.zero = 1'($urandom);
    bus.data_ready = 1'($urandom);
    bus.instr_ready = 1'($urandom);
  endtask
  task automatic trap_cycles(logic [1:0] c, int n);
    repeat (n) begin
      bus.instr_ready = 1'b1;
      bus.data_ready = 1'b1;
      step("trap", ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, c));
    end
  endtask
  task automatic rst_pulse();
    reset = 1'b0;
    mret = 32'd0;
    repeat (2) begin
      bus.instr_ready = 1'b1;
      bus.data_ready = 1'b1;
      step("in_reset", 14'd0);
    end
    reset = 1'b1;
  endtask
  // One whole instruction: fw fetch-wait cycles, dw data-wait cycles.
  task automatic run(logic [6:0] op, logic z, int fw, int dw);
    logic ls;
    ls = op == LD || op == ST;
    for (int k = 0; k < fw && k < TMO; k++) begin
      bus.instr_ready = 1'b0;
      step("fetch_wait", ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00));
    end
    if (fw >= TMO) begin
      trap_cycles(2'b10, 3);
      return;
    end
    bus.instr_ready = 1'b1;
    step("fetch", ex(1, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00));
    bus.Opcode = op;
    step("decode", 14'd0);
    bus.Opcode = 7'($urandom);
    if (!legal(op)) begin
      trap_cycles(2'b01, 3);
      return;
    end
    bus.zero = z;
    step("exec", ex(0, 0, 0, op == BR && z, 0, 0, src(op), 0, 0, aop(op), 0, 2'b00));
    if (op == BR) begin
      mret++;
      return;
    end
    if (ls) begin
      for (int k = 0; k < dw && k < TMO; k++) begin
        bus.data_ready = 1'b0;
        step("mem_wait", ex(0, 0, 0, 0, 0, 0, 1, op == LD, op == ST, 2'b00, 0, 2'b00));
      end
      if (dw >= TMO) begin
        trap_cycles(2'b11, 3);
        return;
      end
      bus.data_ready = 1'b1;
      step("mem", ex(0, 0, 0, 0, 0, 0, 1, op == LD, op == ST, 2'b00, 0, 2'b00));
      if (op == ST) begin
        mret++;
        return;
      end
    end
    step("wb", ex(0, 0, 0, 0, 1, op == LD, src(op), 0, 0, aop(op), 0, 2'b00));
    mret++;
  endtask
  initial begin
    int t0;
    logic [6:0] op;
    logic [6:0] ops [5];
    ops = '{R, I, LD, ST, BR};
    bus.Opcode = 7'd0;
    bus.instr_ready = 1'b0;
    bus.data_ready = 1'b0;
    bus.zero = 1'b0;
    rst_pulse();
    t0 = ncyc;
    run(R, 0, 0, 0);
    run(LD, 0, 0, 0);
    run(ST, 0, 0, 0);
    run(BR, 1, 0, 0);
    chk("zero_wait_cycles", 32'(ncyc - t0), 32'd16);
    chk("zero_wait_retired", bus.retired, 32'd4);
    run(LD, 0, 0, 5);
    run(LD, 0, 0, 15);
    run(ST, 1, 0, 15);
    run(I, 0, 15, 0);
    run(BR, 0, 2, 0);
    repeat (40) run(ops[$urandom_range(0, 4)], 1'($urandom), $urandom_range(0, 4), $urandom_range(0, 4));
    t0 = int'(mret);
    run(BAD, 0, 0, 0);
    chk("illegal_retired", bus.retired, 32'(t0));
    rst_pulse();
    do op = 7'($urandom); while (legal(op));
    run(op, 0, 1, 0);
    rst_pulse();
    run(R, 0, 16, 0);
    rst_pulse();
    run(ST, 0, 0, 16);
    rst_pulse();
    run(LD, 0, 1, 20);
    rst_pulse();
    run(R, 0, 0, 0);
    bus.instr_ready = 1'b1;
    step("fetch", ex(1, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00));
    bus.Opcode = ST;
    step("decode", 14'd0);
    step("exec", ex(0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 2'b00));
    bus.data_ready = 1'b0;
    step("mem_wait", ex(0, 0, 0, 0, 0, 0, 1, 0, 1, 2'b00, 0, 2'b00));
    bus.data_ready = 1'b0;
    @(negedge clk);
    chk("mid_mem_write", 32'(bus.MemWrite), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("async_memwrite_drop", 32'(bus.MemWrite), 32'd0);
    chk("async_all_zero", 32'(obs()), 32'd0);
    chk("async_retired", bus.retired, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    mret = 32'd0;
    run(R, 0, 0, 0);
    run(LD, 0, 1, 2);
    chk("after_reset_retired", bus.retired, 32'd2);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
